// File: rtl/action_executor.sv
// Action executor: applies the matcher's flow-value action words to a header copy, one word per cycle.
// Optional hit/miss/drop counters are compiled in when EXECUTOR_STATS_EN is defined.
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 4
`endif

module action_executor #(
  parameter int PROC_ID = 0,
  parameter int ACT_NUM = `MAX_VAL_LEN/4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic                                   is_match_i,
  input  logic [`MAX_VAL_LEN-1:0][`BYTE_BUS-1:0] flow_val_i,
  input  logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_i,
  input  logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] parsed_hdrs_i,
  input  logic                                   mod_start_i,
  input  logic [7:0]                             mod_miss_port_i,
  input  logic                                   mod_miss_drop_i,
  output logic                                   ready_o,
  output logic                                   busy_o,
  output logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] pkt_hdr_o,
  output logic [7:0]                             fwd_port_o,
  output logic                                   drop_o,
`ifdef EXECUTOR_STATS_EN
  output logic                                   err_o,
  output logic [31:0]                            stat_hit_o,
  output logic [31:0]                            stat_miss_o,
  output logic [31:0]                            stat_drop_o
`else
  output logic                                   err_o
`endif
);
  localparam int NW   = `MAX_VAL_LEN/4;
  localparam int WIW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int HIDW = (`NUM_HEADERS > 1) ? $clog2(`NUM_HEADERS) : 1;
  localparam int HIW  = (`HDR_MAX_LEN > 1) ? $clog2(`HDR_MAX_LEN) : 1;
  localparam logic [WIW-1:0] K_LAST = WIW'(ACT_NUM - 1);
  localparam logic [`BYTE_BUS-1:0] OP_END = 'h00, OP_SET = 'h01, OP_ADD = 'h02,
                                   OP_DEC = 'h03, OP_FWD = 'h04, OP_DROP = 'h05;

  if (ACT_NUM < 1 || ACT_NUM > NW || PROC_ID < 0) begin : g_bad_cfg
    $error("action_executor: ACT_NUM must be in 1..MAX_VAL_LEN/4 and PROC_ID >= 0");
  end

  typedef enum logic [1:0] {IDLE, EXEC, MISS, DONE} state_t;
  state_t state, state_n;

  logic [NW-1:0][3:0][`BYTE_BUS-1:0]     words_q;
  logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] parsed_q;
  logic                                   match_q;
  logic [WIW-1:0]                         k;
  logic [7:0]                             miss_port;
  logic                                   miss_drop;

  logic [`BYTE_BUS-1:0] op, off, opd, nxt_op, tgt;
  logic [3:0]           hid;
  logic [31:0]          idx;
  logic [HIW-1:0]       tidx;
  logic                 tgt_ok, stop;

  // Decode of the current word; a following END ends execution without spending a cycle on it.
  always_comb begin
    op     = words_q[k][0];
    hid    = words_q[k][1][3:0];
    off    = words_q[k][2];
    opd    = words_q[k][3];
    nxt_op = (k == K_LAST) ? OP_END : words_q[k + 1'b1][0];
    idx    = 32'(parsed_q[hid[HIDW-1:0]]) + 32'(off);
    tgt_ok = ({28'b0, hid} < 32'(`NUM_HEADERS)) && (idx < 32'(`HDR_MAX_LEN));
    tidx   = idx[HIW-1:0];
    tgt    = pkt_hdr_o[tidx];
    stop   = (op == OP_END) || (op == OP_DROP) || (k == K_LAST) || (nxt_op == OP_END);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!mod_start_i && start_i) state_n = is_match_i ? EXEC : MISS;
      EXEC:    if (stop) state_n = DONE;
      MISS:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy_o  = (state == EXEC) || (state == MISS);
  assign ready_o = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_hdr_o  <= '0;
      fwd_port_o <= '0;
      drop_o     <= 1'b0;
      err_o      <= 1'b0;
      words_q    <= '0;
      parsed_q   <= '0;
      match_q    <= 1'b0;
      k          <= '0;
      miss_port  <= '0;
      miss_drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mod_start_i) begin
            miss_port <= mod_miss_port_i;
            miss_drop <= mod_miss_drop_i;
          end else if (start_i) begin
            pkt_hdr_o  <= pkt_hdr_i;
            words_q    <= flow_val_i;
            parsed_q   <= parsed_hdrs_i;
            match_q    <= is_match_i;
            fwd_port_o <= '0;
            drop_o     <= 1'b0;
            err_o      <= 1'b0;
            k          <= '0;
          end
        end
        EXEC: begin
          k <= k + 1'b1;
          case (op)
            OP_END: ;
            OP_SET, OP_ADD, OP_DEC: begin
              if (!tgt_ok)            err_o <= 1'b1;
              else if (op == OP_SET)  pkt_hdr_o[tidx] <= opd;
              else if (op == OP_ADD)  pkt_hdr_o[tidx] <= tgt + opd;
              else if (tgt != '0)     pkt_hdr_o[tidx] <= tgt - 1'b1;
            end
            OP_FWD:  fwd_port_o <= opd;
            OP_DROP: drop_o     <= 1'b1;
            default: err_o      <= 1'b1;
          endcase
        end
        MISS: begin
          fwd_port_o <= miss_port;
          drop_o     <= miss_drop;
        end
        default: ;
      endcase
    end
  end

`ifdef EXECUTOR_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hit_o  <= '0;
      stat_miss_o <= '0;
      stat_drop_o <= '0;
    end else if (state == DONE) begin
      if (match_q) stat_hit_o  <= stat_hit_o + 1'b1;
      else         stat_miss_o <= stat_miss_o + 1'b1;
      if (drop_o)  stat_drop_o <= stat_drop_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_action_executor.sv
// Self-checking bench for action_executor: directed scenarios plus randomized packets against a list-walking model.
`ifndef BYTE_BUS
`define BYTE_BUS 8
`endif
`ifndef MAX_VAL_LEN
`define MAX_VAL_LEN 16
`endif
`ifndef HDR_MAX_LEN
`define HDR_MAX_LEN 64
`endif
`ifndef DATA_BUS
`define DATA_BUS 32
`endif
`ifndef NUM_HEADERS
`define NUM_HEADERS 4
`endif

module tb_action_executor;
  localparam int A  = 3;
  localparam int HL = `HDR_MAX_LEN;
  localparam int NH = `NUM_HEADERS;
  localparam int VL = `MAX_VAL_LEN;

  typedef logic [`MAX_VAL_LEN-1:0][`BYTE_BUS-1:0] fv_t;
  typedef logic [`HDR_MAX_LEN-1:0][`BYTE_BUS-1:0] hdr_t;
  typedef logic [`NUM_HEADERS-1:0][`DATA_BUS-1:0] ph_t;

  logic clk = 0, rst = 0, start = 0, is_match = 0, mod_start = 0, mod_drop = 0;
  logic [7:0] mod_port = '0;
  fv_t  flow_val = '0;
  hdr_t pkt_hdr = '0;
  ph_t  parsed = '0;
  logic ready, busy, drop, err;
  hdr_t hdr_out;
  logic [7:0] fwd;
`ifdef EXECUTOR_STATS_EN
  logic [31:0] st_hit, st_miss, st_drop;
`endif

  int checks = 0, errors = 0;
  logic [7:0] cfg_port = '0;
  logic       cfg_drop = 1'b0;

  always #5 clk = ~clk;

  action_executor #(.PROC_ID(0), .ACT_NUM(A)) dut (
    .clk(clk), .rst(rst), .start_i(start), .is_match_i(is_match),
    .flow_val_i(flow_val), .pkt_hdr_i(pkt_hdr), .parsed_hdrs_i(parsed),
    .mod_start_i(mod_start), .mod_miss_port_i(mod_port), .mod_miss_drop_i(mod_drop),
    .ready_o(ready), .busy_o(busy), .pkt_hdr_o(hdr_out), .fwd_port_o(fwd),
    .drop_o(drop),
`ifdef EXECUTOR_STATS_EN
    .err_o(err), .stat_hit_o(st_hit), .stat_miss_o(st_miss), .stat_drop_o(st_drop)
`else
    .err_o(err)
`endif
  );

  // Walks the action list as written: END/DROP stop, bad words are skipped with an error.
  // A trailing END costs no cycle, except when it is the very first word.
  task automatic model(input logic m, input fv_t fv, input hdr_t h, input ph_t ph,
                       output hdr_t he, output logic [7:0] fe, output logic de,
                       output logic ee, output int lat);
    int n;
    logic [7:0] op, off, opd;
    logic [3:0] id;
    logic [31:0] t;
    he = h; fe = '0; de = 1'b0; ee = 1'b0; n = 0;
    if (!m) begin
      fe = cfg_port; de = cfg_drop; lat = 2;
      return;
    end
    for (int w = 0; w < A; w++) begin
      op = fv[4*w]; id = fv[4*w+1][3:0]; off = fv[4*w+2]; opd = fv[4*w+3];
      if (op == 8'h00 && w > 0) break;
      n++;
      if (op == 8'h00) break;
      if (op == 8'h05) begin de = 1'b1; break; end
      if (op == 8'h04) fe = opd;
      else if (op >= 8'h01 && op <= 8'h03) begin
        if (int'(id) >= NH) ee = 1'b1;
        else begin
          t = ph[id] + 32'(off);
          if (t >= 32'(HL)) ee = 1'b1;
          else if (op == 8'h01) he[t] = opd;
          else if (op == 8'h02) he[t] = he[t] + opd;
          else if (he[t] != 0) he[t] = he[t] - 8'd1;
        end
      end else ee = 1'b1;
    end
    lat = n + 1;
  endtask

  task automatic send(input logic m, input fv_t fv, input hdr_t h, input ph_t ph, output int lat);
    @(negedge clk);
    is_match = m; flow_val = fv; pkt_hdr = h; parsed = ph; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!ready && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic d);
    @(negedge clk);
    mod_start = 1'b1; mod_port = p; mod_drop = d;
    @(negedge clk);
    mod_start = 1'b0;
    cfg_port = p; cfg_drop = d;
  endtask

  function automatic hdr_t rand_hdr();
    hdr_t h;
    for (int i = 0; i < HL; i++) h[i] = 8'($urandom);
    return h;
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; is_match = 1'b1; pkt_hdr = rand_hdr();
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, drop, err, fwd} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl got %h exp 000", {ready, busy, drop, err, fwd});
    end
    checks++;
    if (hdr_out !== '0) begin errors++; $display("FAIL reset_hdr got %h exp 0", hdr_out); end
    start = 1'b0; rst = 1'b1;
    cfg_port = '0; cfg_drop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set();
    fv_t fv = '0; hdr_t h, he; ph_t ph = '0; int lat;
    h = rand_hdr(); ph[1] = 14;
    fv[0] = 8'h01; fv[1] = 8'h01; fv[2] = 8'h08; fv[3] = 8'hAB;
    he = h; he[22] = 8'hAB;
    send(1'b1, fv, h, ph, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL set_latency got %0d exp 2", lat); end
    checks++;
    if (hdr_out !== he) begin errors++; $display("FAIL set_hdr got %h exp %h", hdr_out, he); end
    checks++;
    if ({err, drop, fwd} !== 10'h0) begin errors++; $display("FAIL set_flags got %h exp 0", {err, drop, fwd}); end
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || hdr_out !== he) begin
      errors++; $display("FAIL set_hold ready %b hdr %h exp ready 0 hdr %h", ready, hdr_out, he);
    end
  endtask

  task automatic test_add_dec();
    fv_t fv = '0; hdr_t h, he; ph_t ph = '0; int lat;
    h = rand_hdr(); h[20] = 8'hF0; h[21] = 8'h00;
    fv[3:0]  = {8'h20, 8'h14, 8'h00, 8'h02};
    fv[7:4]  = {8'h00, 8'h15, 8'h00, 8'h03};
    fv[11:8] = {8'h07, 8'h00, 8'h00, 8'h04};
    he = h; he[20] = 8'h10;
    send(1'b1, fv, h, ph, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL adddec_latency got %0d exp 4", lat); end
    checks++;
    if (hdr_out !== he) begin errors++; $display("FAIL adddec_hdr got %h exp %h", hdr_out, he); end
    checks++;
    if (fwd !== 8'h07 || err !== 1'b0) begin errors++; $display("FAIL adddec_fwd got %h/%b exp 07/0", fwd, err); end
  endtask

  task automatic test_miss();
    fv_t fv; hdr_t h; ph_t ph = '0; int lat;
    set_cfg(8'h03, 1'b1);
    h = rand_hdr(); fv = '0; fv[3:0] = {8'hFF, 8'h00, 8'h00, 8'h01};
    send(1'b0, fv, h, ph, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL miss_latency got %0d exp 2", lat); end
    checks++;
    if (hdr_out !== h || fwd !== 8'h03 || drop !== 1'b1) begin
      errors++; $display("FAIL miss_result fwd %h drop %b hdr_ok %b exp 03 1 1", fwd, drop, hdr_out === h);
    end
    // config strobe wins over a simultaneous start
    @(negedge clk);
    start = 1'b1; is_match = 1'b0; mod_start = 1'b1; mod_port = 8'h05; mod_drop = 1'b0;
    @(negedge clk);
    start = 1'b0; mod_start = 1'b0;
    cfg_port = 8'h05; cfg_drop = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL mod_priority busy %b ready %b exp 0 0", busy, ready); end
    send(1'b0, fv, h, ph, lat);
    checks++;
    if (fwd !== 8'h05 || drop !== 1'b0) begin errors++; $display("FAIL miss_newcfg got %h/%b exp 05/0", fwd, drop); end
  endtask

  task automatic test_drop();
    fv_t fv = '0; hdr_t h; ph_t ph = '0; int lat;
    h = rand_hdr();
    fv[3:0] = {8'h00, 8'h00, 8'h00, 8'h05};
    fv[7:4] = {8'hFF, 8'h00, 8'h00, 8'h01};
    send(1'b1, fv, h, ph, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL drop_latency got %0d exp 2", lat); end
    checks++;
    if (drop !== 1'b1 || hdr_out !== h) begin
      errors++; $display("FAIL drop_result drop %b hdr0 %h exp 1 %h", drop, hdr_out[0], h[0]);
    end
  endtask

  task automatic test_errors();
    fv_t fv = '0; hdr_t h, he; ph_t ph = '0; int lat;
    h = rand_hdr(); ph[2] = 60;
    fv[3:0]  = {8'h55, 8'h04, 8'h02, 8'h01};
    fv[7:4]  = {8'h00, 8'h00, 8'h00, 8'h09};
    fv[11:8] = {8'h66, 8'h03, 8'h00, 8'h01};
    he = h; he[3] = 8'h66;
    send(1'b1, fv, h, ph, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL err_latency got %0d exp 4", lat); end
    checks++;
    if (err !== 1'b1 || hdr_out !== he) begin
      errors++; $display("FAIL err_result err %b hdr %h exp 1 %h", err, hdr_out, he);
    end
  endtask

  task automatic test_busy_ignore();
    fv_t fv = '0, fv2; hdr_t h, he; ph_t ph = '0; logic [7:0] fe; logic de, ee;
    int lat, cnt = 0;
    h = rand_hdr();
    fv[3:0] = {8'h01, 8'h00, 8'h00, 8'h02};
    fv[7:4] = {8'h01, 8'h01, 8'h00, 8'h02};
    fv[11:8] = {8'h01, 8'h02, 8'h00, 8'h02};
    model(1'b1, fv, h, ph, he, fe, de, ee, lat);
    fv2 = '0; fv2[3:0] = {8'h00, 8'h00, 8'h00, 8'h05};
    @(negedge clk);
    is_match = 1'b1; flow_val = fv; pkt_hdr = h; parsed = ph; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    flow_val = fv2; pkt_hdr = '0; start = 1'b1;
    mod_start = 1'b1; mod_port = 8'h99; mod_drop = 1'b1;
    @(negedge clk); start = 1'b0; mod_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ready) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL busy_ready_count got %0d exp 1", cnt); end
    checks++;
    if (hdr_out !== he || drop !== 1'b0) begin
      errors++; $display("FAIL busy_result hdr %h drop %b exp %h 0", hdr_out, drop, he);
    end
    send(1'b0, fv2, h, ph, lat);
    checks++;
    if (fwd !== cfg_port || drop !== cfg_drop) begin
      errors++; $display("FAIL busy_cfg got %h/%b exp %h/%b", fwd, drop, cfg_port, cfg_drop);
    end
  endtask

  task automatic test_reset_mid();
    fv_t fv = '0; hdr_t h; ph_t ph = '0; int lat, cnt = 0;
    h = rand_hdr(); h[5] = 8'h10;
    fv[3:0] = {8'h33, 8'h00, 8'h00, 8'h04};
    fv[7:4] = {8'h01, 8'h00, 8'h05, 8'h02};
    fv[11:8] = {8'h01, 8'h00, 8'h05, 8'h02};
    @(negedge clk);
    is_match = 1'b1; flow_val = fv; pkt_hdr = h; parsed = ph; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ready, busy, drop, err, fwd} !== 12'h0 || hdr_out !== '0) begin
      errors++; $display("FAIL midreset_outputs got %h hdr_zero %b exp 000 1", {ready, busy, drop, err, fwd}, hdr_out === '0);
    end
    cfg_port = '0; cfg_drop = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL midreset_ready got %0d pulses exp 0", cnt); end
    send(1'b0, fv, h, ph, lat);
    checks++;
    if (fwd !== 8'h00 || drop !== 1'b0 || hdr_out !== h) begin
      errors++; $display("FAIL midreset_cfg got %h/%b exp 00/0", fwd, drop);
    end
  endtask

  task automatic test_random();
    fv_t fv; hdr_t h, he; ph_t ph; logic [7:0] fe; logic de, ee, m;
    int lat, lat_e, r;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) set_cfg(8'($urandom), 1'($urandom));
      h = rand_hdr();
      for (int j = 0; j < NH; j++) ph[j] = 32'($urandom_range(0, 40));
      for (int j = 0; j < VL; j++) fv[j] = 8'($urandom);
      for (int w = 0; w < A; w++) begin
        r = $urandom_range(0, 12);
        fv[4*w] = (r == 0) ? 8'h00 : (r <= 3) ? 8'h01 : (r <= 6) ? 8'h02 :
                  (r <= 9) ? 8'h03 : (r == 10) ? 8'h04 : (r == 11) ? 8'h05 :
                  8'($urandom_range(6, 255));
        fv[4*w+1] = 8'($urandom_range(0, 5));
        fv[4*w+2] = 8'($urandom_range(0, 40));
      end
      m = ($urandom_range(0, 3) != 0);
      model(m, fv, h, ph, he, fe, de, ee, lat_e);
      send(m, fv, h, ph, lat);
      checks++;
      if (lat !== lat_e) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", it, lat, lat_e); end
      checks++;
      if (hdr_out !== he) begin errors++; $display("FAIL rnd%0d_hdr got %h exp %h", it, hdr_out, he); end
      checks++;
      if ({fwd, drop, err} !== {fe, de, ee}) begin
        errors++; $display("FAIL rnd%0d_flags got %h exp %h", it, {fwd, drop, err}, {fe, de, ee});
      end
    end
  endtask

`ifdef EXECUTOR_STATS_EN
  task automatic test_stats();
    fv_t fv = '0; hdr_t h; ph_t ph = '0; int lat;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    cfg_port = '0; cfg_drop = 1'b0;
    checks++;
    if ({st_hit, st_miss, st_drop} !== 96'h0) begin errors++; $display("FAIL stats_reset got %h exp 0", {st_hit, st_miss, st_drop}); end
    h = rand_hdr();
    fv[3:0] = {8'h11, 8'h00, 8'h01, 8'h01};
    send(1'b1, fv, h, ph, lat);
    fv[3:0] = {8'h00, 8'h00, 8'h00, 8'h05};
    send(1'b1, fv, h, ph, lat);
    send(1'b0, fv, h, ph, lat);
    @(negedge clk);
    checks++;
    if (st_hit !== 32'd2 || st_miss !== 32'd1 || st_drop !== 32'd1) begin
      errors++; $display("FAIL stats_count got %0d/%0d/%0d exp 2/1/1", st_hit, st_miss, st_drop);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_set();
    test_add_dec();
    test_miss();
    test_drop();
    test_errors();
    test_busy_ignore();
    test_reset_mid();
    test_random();
`ifdef EXECUTOR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
